// File: rtl/axil_csr_bank_pkg.sv
// Shared response codes, FSM state types and the byte-strobe merge helper
// for the AXI4-Lite CSR bank.
package axil_csr_bank_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

  // Widest register the merge helper supports; callers zero-extend and slice.
  localparam int CSR_MAX_DW = 1024;

  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_RESP}            rd_state_e;

  function automatic logic [CSR_MAX_DW-1:0] strb_merge(
    input logic [CSR_MAX_DW-1:0]   old_v,
    input logic [CSR_MAX_DW-1:0]   new_v,
    input logic [CSR_MAX_DW/8-1:0] strb
  );
    logic [CSR_MAX_DW-1:0] res;
    res = old_v;
    for (int b = 0; b < CSR_MAX_DW/8; b++)
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axil_csr_rd_chan.sv
// AXI4-Lite read channel: single-outstanding read FSM, word decode and
// registered rdata/rresp for the CSR bank.
module axil_csr_rd_chan
  import axil_csr_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RW     = 32,
  parameter int NUM_RO     = 32
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               arvalid,
  output logic                               arready,
  input  logic [ADDR_WIDTH-1:0]              araddr,
  output logic                               rvalid,
  input  logic                               rready,
  output logic [DATA_WIDTH-1:0]              rdata,
  output logic [1:0]                         rresp,
  input  logic [NUM_RW-1:0][DATA_WIDTH-1:0]  ctrl,
  input  logic [NUM_RO-1:0][DATA_WIDTH-1:0]  status
);

  localparam int IDX_LO = $clog2(DATA_WIDTH/8);
  localparam int IDX_W  = $clog2(NUM_RW + NUM_RO);

  rd_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;
  logic                  addr_unused;

  assign idx         = araddr[IDX_LO +: IDX_W];
  assign addr_unused = ^araddr;
  assign arready     = (state_q == RD_IDLE);
  assign rvalid      = (state_q == RD_RESP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE: if (arvalid) state_d = RD_RESP;
      RD_RESP: if (rready)  state_d = RD_IDLE;
      default:              state_d = RD_IDLE;
    endcase
  end

  // Holes past the last status word read as zero with DECERR.
  always_comb begin
    rd_data = '0;
    rd_resp = AXIL_RESP_DECERR;
    for (int i = 0; i < NUM_RW; i++)
      if (idx == IDX_W'(i)) begin
        rd_data = ctrl[i];
        rd_resp = AXIL_RESP_OKAY;
      end
    for (int k = 0; k < NUM_RO; k++)
      if (idx == IDX_W'(NUM_RW + k)) begin
        rd_data = status[k];
        rd_resp = AXIL_RESP_OKAY;
      end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RD_IDLE;
      rdata   <= '0;
      rresp   <= AXIL_RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (arvalid && arready) begin
        rdata <= rd_data;
        rresp <= rd_resp;
      end
    end
  end

endmodule

// File: rtl/axil_csr_bank.sv
// AXI4-Lite register bank: NUM_RW control words with byte strobes and
// per-register commit pulses, plus NUM_RO read-only status words.
module axil_csr_bank
  import axil_csr_bank_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_RW      = 32,
  parameter int                    NUM_RO      = 32,
  parameter int                    CMD_IDX     = 0,
  parameter logic [DATA_WIDTH-1:0] CMD_RST_VAL = 32'hDEADBEEF
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  input  logic [NUM_RO*DATA_WIDTH-1:0]   status_i,
  output logic [NUM_RW*DATA_WIDTH-1:0]   ctrl_o,
  output logic [NUM_RW-1:0]              wr_pulse_o,
  output logic                           cmd_new_o
);

  localparam int STRB_W = DATA_WIDTH/8;
  localparam int IDX_LO = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_RW + NUM_RO);

  wr_state_e                         state_q, state_d;
  logic                              aw_full_q, w_full_q;
  logic [IDX_W-1:0]                  aw_idx_q;
  logic [DATA_WIDTH-1:0]             w_data_q;
  logic [STRB_W-1:0]                 w_strb_q;
  logic [1:0]                        bresp_q;
  logic [NUM_RW-1:0]                 wr_pulse_q, wr_hit;
  logic [NUM_RW-1:0][DATA_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0]             wr_old, wr_new;
  logic [CSR_MAX_DW-1:0]             merged;
  logic                              aw_hs, w_hs, commit, wr_is_rw, wr_is_ro;
  logic [1:0]                        wr_resp;
  logic                              addr_unused, merge_unused;

  assign addr_unused = ^awaddr;
  assign awready     = (state_q == WR_IDLE) && !aw_full_q;
  assign wready      = (state_q == WR_IDLE) && !w_full_q;
  assign bvalid      = (state_q == WR_RESP);
  assign bresp       = bresp_q;
  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign commit      = (state_q == WR_COMMIT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WR_IDLE:   if ((aw_full_q || aw_hs) && (w_full_q || w_hs)) state_d = WR_COMMIT;
      WR_COMMIT: state_d = WR_RESP;
      WR_RESP:   if (bready) state_d = WR_IDLE;
      default:   state_d = WR_IDLE;
    endcase
  end

  assign wr_is_rw = {1'b0, aw_idx_q} < (IDX_W+1)'(NUM_RW);
  assign wr_is_ro = !wr_is_rw && ({1'b0, aw_idx_q} < (IDX_W+1)'(NUM_RW + NUM_RO));
  assign wr_resp  = wr_is_rw ? AXIL_RESP_OKAY :
                    wr_is_ro ? AXIL_RESP_SLVERR : AXIL_RESP_DECERR;

  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (aw_idx_q == IDX_W'(i)) wr_old = ctrl_q[i];
  end

  assign merged       = strb_merge(CSR_MAX_DW'(wr_old), CSR_MAX_DW'(w_data_q),
                                   (CSR_MAX_DW/8)'(w_strb_q));
  assign wr_new       = merged[DATA_WIDTH-1:0];
  assign merge_unused = ^merged[CSR_MAX_DW-1:DATA_WIDTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= WR_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= AXIL_RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_pulse_q <= wr_hit;
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= awaddr[IDX_LO +: IDX_W];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bresp_q   <= wr_resp;
      end
    end
  end

  // A zero strobe still counts as a commit, so the pulse fires regardless.
  for (genvar i = 0; i < NUM_RW; i++) begin : g_reg
    localparam logic [DATA_WIDTH-1:0] RST_VAL = (i == CMD_IDX) ? CMD_RST_VAL : '0;
    assign wr_hit[i] = commit && wr_is_rw && (aw_idx_q == IDX_W'(i));
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          ctrl_q[i] <= RST_VAL;
      else if (wr_hit[i]) ctrl_q[i] <= wr_new;
    end
  end

  assign ctrl_o     = ctrl_q;
  assign wr_pulse_o = wr_pulse_q;
  assign cmd_new_o  = wr_pulse_q[CMD_IDX];

  axil_csr_rd_chan #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_RW     (NUM_RW),
    .NUM_RO     (NUM_RO)
  ) u_rd_chan (
    .clk     (clk),
    .rstn    (rstn),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp),
    .ctrl    (ctrl_q),
    .status  (status_i)
  );

endmodule
